// File: rtl/barcode_keypad_entry_pkg.sv
// rtl/barcode_keypad_entry_pkg.sv - shared encodings for the barcode/keypad entry front end
package barcode_keypad_entry_pkg;
  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_ENTRY  = 2'd0,
    ST_SELECT = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam logic KIND_BARCODE = 1'b0;
  localparam logic KIND_ITEM    = 1'b1;

  function automatic state_t mode_state(input logic mode);
    return mode ? ST_SELECT : ST_ENTRY;
  endfunction
endpackage

// File: rtl/barcode_keypad_entry_if.sv
// rtl/barcode_keypad_entry_if.sv - committed-transaction handshake towards the lookup/VGA logic
interface barcode_keypad_entry_if #(parameter int DIGITS = 4);
  import barcode_keypad_entry_pkg::*;
  logic                      out_valid;
  logic                      out_kind;
  logic [BCD_W*DIGITS-1:0]   out_data;
  logic                      out_ack;

  modport master (output out_valid, output out_kind, output out_data, input out_ack);
  modport slave  (input out_valid, input out_kind, input out_data, output out_ack);
endinterface

// File: rtl/barcode_keypad_entry_debounce.sv
// rtl/barcode_keypad_entry_debounce.sv - per-key synchroniser, stable-level filter and press pulse
module key_debounce #(
  parameter int DB_CYC = 4
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DB_CYC + 1);

  logic          s1, s2, level;
  logic [CW-1:0] cnt;

  // level only follows s2 after it has disagreed for DB_CYC consecutive cycles
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= key_n;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYC - 1)) begin
        cnt   <= '0;
        level <= s2;
        press <= ~s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/barcode_keypad_entry.sv
// rtl/barcode_keypad_entry.sv - key/switch front end producing barcode and item-select transactions
module barcode_keypad_entry
  import barcode_keypad_entry_pkg::*;
#(
  parameter int NUM_KEYS = 4,
  parameter int DIGITS   = 4,
  parameter int ITEMS    = 8,
  parameter int DB_CYC   = 4
) (
  input  logic                         CLOCK_50,
  input  logic                         RESET,
  input  logic [NUM_KEYS-1:0]          key_n,
  input  logic                         shift_sw,
  input  logic                         mode_sw,
  barcode_keypad_entry_if.master       bus,
  output logic [$clog2(DIGITS+1)-1:0]  digit_cnt,
  output logic [$clog2(ITEMS)-1:0]     cursor,
  output logic                         err_pulse
);
  localparam int DW   = BCD_W * DIGITS;
  localparam int CNW  = $clog2(DIGITS + 1);
  localparam int CURW = $clog2(ITEMS);

  logic [NUM_KEYS-1:0] press;
  logic                ev_any;
  int                  ev_key;
  logic [BCD_W-1:0]    ev_digit;

  state_t              state;
  logic [DW-1:0]       bcd_q;
  logic                valid_q, kind_q;
  logic [DW-1:0]       data_q;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(.DB_CYC(DB_CYC)) u_db (
      .CLOCK_50 (CLOCK_50),
      .RESET    (RESET),
      .key_n    (key_n[k]),
      .press    (press[k])
    );
  end

  // descending scan so the lowest-index pressed key is the one left standing
  always_comb begin
    ev_any   = 1'b0;
    ev_key   = 0;
    ev_digit = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (press[i]) begin
        ev_any   = 1'b1;
        ev_key   = i;
        ev_digit = BCD_W'(NUM_KEYS - i);
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_kind  = kind_q;
  assign bus.out_data  = data_q;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state     <= ST_ENTRY;
      bcd_q     <= '0;
      digit_cnt <= '0;
      cursor    <= '0;
      err_pulse <= 1'b0;
      valid_q   <= 1'b0;
      kind_q    <= KIND_BARCODE;
      data_q    <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (state == ST_HOLD) begin
        if (ev_any) err_pulse <= 1'b1;
        if (bus.out_ack) begin
          valid_q <= 1'b0;
          state   <= mode_state(mode_sw);
        end
      end else if (state != mode_state(mode_sw)) begin
        state     <= mode_state(mode_sw);
        bcd_q     <= '0;
        digit_cnt <= '0;
      end else if (ev_any && state == ST_ENTRY) begin
        if (ev_key != 0) begin
          if (digit_cnt < CNW'(DIGITS)) begin
            bcd_q     <= (bcd_q << BCD_W) | DW'(ev_digit);
            digit_cnt <= digit_cnt + CNW'(1);
          end else begin
            err_pulse <= 1'b1;
          end
        end else if (!shift_sw) begin
          if (digit_cnt == '0) begin
            err_pulse <= 1'b1;
          end else begin
            bcd_q     <= bcd_q >> BCD_W;
            digit_cnt <= digit_cnt - CNW'(1);
          end
        end else if (digit_cnt == CNW'(DIGITS)) begin
          valid_q   <= 1'b1;
          kind_q    <= KIND_BARCODE;
          data_q    <= bcd_q;
          state     <= ST_HOLD;
          bcd_q     <= '0;
          digit_cnt <= '0;
        end else begin
          err_pulse <= 1'b1;
        end
      end else if (ev_any) begin
        if (ev_key == 0) begin
          valid_q <= 1'b1;
          kind_q  <= KIND_ITEM;
          data_q  <= DW'(cursor);
          state   <= ST_HOLD;
        end else if (ev_key == 1) begin
          cursor <= (cursor == CURW'(ITEMS - 1)) ? '0 : cursor + CURW'(1);
        end else if (ev_key == 2) begin
          cursor <= (cursor == '0) ? CURW'(ITEMS - 1) : cursor - CURW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_barcode_keypad_entry.sv
// tb/tb_barcode_keypad_entry.sv - scoreboard bench for barcode_keypad_entry
module tb_barcode_keypad_entry;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_n;
  logic       shift_sw, mode_sw;
  logic [2:0] digit_cnt;
  logic [2:0] cursor;
  logic       err_pulse;

  int total = 0;
  int bad   = 0;
  int err_cnt = 0;
  logic valid_d = 1'b0;

  typedef struct { logic kind; logic [15:0] data; } txn_t;
  txn_t exp_q[$];

  barcode_keypad_entry_if #(.DIGITS(4)) bus ();

  barcode_keypad_entry #(.NUM_KEYS(4), .DIGITS(4), .ITEMS(8), .DB_CYC(4)) dut (
    .CLOCK_50  (clk),
    .RESET     (rst),
    .key_n     (key_n),
    .shift_sw  (shift_sw),
    .mode_sw   (mode_sw),
    .bus       (bus),
    .digit_cnt (digit_cnt),
    .cursor    (cursor),
    .err_pulse (err_pulse)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && bus.out_valid && !valid_d) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL spurious_valid kind=%0d data=%h expected no transaction", bus.out_kind, bus.out_data);
      end else begin
        txn_t e;
        e = exp_q.pop_front();
        if (bus.out_kind !== e.kind || bus.out_data !== e.data) begin
          bad++;
          $display("FAIL txn kind=%0d data=%h expected kind=%0d data=%h",
                   bus.out_kind, bus.out_data, e.kind, e.data);
        end
      end
    end
    valid_d = bus.out_valid;
    if (err_pulse) err_cnt++;
  end

  task automatic press(input logic [3:0] mask);
    @(negedge clk);
    key_n = ~mask;
    repeat (10) @(negedge clk);
    key_n = 4'hF;
    repeat (12) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s pending=%0d expected=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_ack();
    @(negedge clk);
    bus.out_ack = 1'b1;
    @(negedge clk);
    bus.out_ack = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL ack_valid got=%0d expected=0", bus.out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; key_n = 4'hF; shift_sw = 1'b0; mode_sw = 1'b0; bus.out_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_kind !== 1'b0 || bus.out_data !== 16'h0 ||
        digit_cnt !== 3'd0 || cursor !== 3'd0 || err_pulse !== 1'b0) begin
      bad++;
      $display("FAIL reset v=%0d k=%0d d=%h cnt=%0d cur=%0d err=%0d expected all zero",
               bus.out_valid, bus.out_kind, bus.out_data, digit_cnt, cursor, err_pulse);
    end
  endtask

  task automatic test_commit_barcode();
    press(4'b1000); press(4'b0100); press(4'b1000); press(4'b0010);
    chk("entry_cnt4", 32'(digit_cnt), 32'd4);
    shift_sw = 1'b1;
    exp_q.push_back('{1'b0, 16'h1213});
    press(4'b0001);
    check_drained("commit_barcode");
    chk("commit_cnt0", 32'(digit_cnt), 32'd0);
    chk("commit_valid", 32'(bus.out_valid), 32'd1);
    do_ack();
  endtask

  task automatic test_backspace();
    int e0;
    shift_sw = 1'b0;
    press(4'b1000); press(4'b0100);
    press(4'b0001);
    chk("bs_cnt1", 32'(digit_cnt), 32'd1);
    chk("bs_buf1", 32'(dut.bcd_q), 32'h0001);
    e0 = err_cnt;
    press(4'b0001);
    chk("bs_first_noerr", 32'(err_cnt - e0), 32'd0);
    press(4'b0001);
    chk("bs_empty_err", 32'(err_cnt - e0), 32'd1);
    chk("bs_cnt0", 32'(digit_cnt), 32'd0);
  endtask

  task automatic test_full_and_short();
    int e0;
    e0 = err_cnt;
    for (int i = 0; i < 5; i++) press(4'b1000);
    chk("full_err", 32'(err_cnt - e0), 32'd1);
    chk("full_buf", 32'(dut.bcd_q), 32'h1111);
    chk("full_cnt", 32'(digit_cnt), 32'd4);
    press(4'b0001);
    shift_sw = 1'b1;
    e0 = err_cnt;
    press(4'b0001);
    chk("short_err", 32'(err_cnt - e0), 32'd1);
    chk("short_novalid", 32'(bus.out_valid), 32'd0);
    chk("short_kept", 32'(dut.bcd_q), 32'h0111);
    shift_sw = 1'b0;
  endtask

  task automatic test_select();
    int e0;
    mode_sw = 1'b1;
    repeat (3) @(negedge clk);
    chk("sel_clear", 32'(digit_cnt), 32'd0);
    press(4'b0100);
    chk("sel_wrap_dn", 32'(cursor), 32'd7);
    press(4'b0010);
    chk("sel_wrap_up", 32'(cursor), 32'd0);
    e0 = err_cnt;
    press(4'b1000);
    chk("sel_key3_ignored", 32'(cursor), 32'd0);
    chk("sel_key3_noerr", 32'(err_cnt - e0), 32'd0);
    exp_q.push_back('{1'b1, 16'h0000});
    press(4'b0001);
    check_drained("commit_item");
  endtask

  task automatic test_hold();
    int e0;
    e0 = err_cnt;
    for (int i = 0; i < 3; i++) begin
      press(4'b0010);
      chk("hold_data", {15'd0, bus.out_valid, bus.out_kind, bus.out_data[14:0]}, 32'h0001_8000 >> 0 | 32'h0000_0000);
    end
    chk("hold_err_per_press", 32'(err_cnt - e0), 32'd3);
    chk("hold_cursor", 32'(cursor), 32'd0);
    do_ack();
  endtask

  task automatic test_glitch_priority_reset();
    int e0;
    mode_sw = 1'b0; shift_sw = 1'b0;
    repeat (3) @(negedge clk);
    e0 = err_cnt;
    key_n = 4'b0111;
    repeat (2) @(negedge clk);
    key_n = 4'hF;
    repeat (20) @(negedge clk);
    chk("glitch_cnt", 32'(digit_cnt), 32'd0);
    chk("glitch_noerr", 32'(err_cnt - e0), 32'd0);
    press(4'b1010);
    chk("prio_cnt", 32'(digit_cnt), 32'd1);
    chk("prio_buf", 32'(dut.bcd_q), 32'h0003);
    press(4'b1000); press(4'b1000); press(4'b1000);
    shift_sw = 1'b1;
    exp_q.push_back('{1'b0, 16'h3111});
    press(4'b0001);
    check_drained("commit_before_reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_kind !== 1'b0 || bus.out_data !== 16'h0 ||
        digit_cnt !== 3'd0 || cursor !== 3'd0 || err_pulse !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_hold v=%0d k=%0d d=%h cnt=%0d cur=%0d err=%0d expected all zero",
               bus.out_valid, bus.out_kind, bus.out_data, digit_cnt, cursor, err_pulse);
    end
  endtask

  initial begin
    test_reset();
    test_commit_barcode();
    test_backspace();
    test_full_and_short();
    test_select();
    test_hold();
    test_glitch_priority_reset();
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
